// File: rtl/ifetch_line_buffer.sv
// Instruction fetch line buffer: one 64-byte Sysbus read per line, delivered as 32-bit words.
// Optional macro IFB_BYPASS_EN presents words while the line is still filling.
//
// state | meaning
// IDLE  | out of reset, capture entry PC
// REQ   | read request held on the bus until acknowledged
// RESP  | collecting beats (dropped when a redirect arrived meanwhile)
// DRAIN | presenting buffered words to decode
module ifetch_line_buffer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    input  logic                      redirect,
    input  logic [63:0]               redirect_pc,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [63:0]               instr_pc,
    input  logic                      instr_ready
);

    localparam int BEAT_W = $clog2(LINE_BEATS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = {1'b1, 4'b0001, {(BUS_TAG_WIDTH-5){1'b0}}};

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_e;

    state_e                                     state_q, state_d;
    logic [63:0]                                fetch_pc_q, fetch_pc_d;
    logic                                       discard_q, discard_d;
    logic [BEAT_W-1:0]                          beat_q, beat_d;
    logic [3:0]                                 idx_q, idx_d;
    logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0]  line_q, line_d;

    logic                      bus_reqcyc_q, bus_reqcyc_d;
    logic [BUS_DATA_WIDTH-1:0] bus_req_q, bus_req_d;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_q, bus_reqtag_d;
    logic                      instr_valid_q, instr_valid_d;
    logic [31:0]               instr_q, instr_d;
    logic [63:0]               instr_pc_q, instr_pc_d;

    logic                      hs;
    logic [63:0]               redir_pc;
    logic [BUS_DATA_WIDTH-1:0] word_beat;

    // Tag is never checked (single outstanding transaction); low PC bits are forced to zero.
    logic unused_bits;
    assign unused_bits = ^{bus_resptag, redirect_pc[1:0]};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        line_d     = line_q;
        hs         = instr_valid_q & instr_ready;
        redir_pc   = {redirect_pc[63:2], 2'b00};

        case (state_q)
            IDLE: begin
                fetch_pc_d = entry;
                state_d    = REQ;
            end
            REQ: begin
                if (redirect) begin
                    discard_d  = 1'b1;
                    fetch_pc_d = redir_pc;
                end
                if (bus_reqack) begin
                    state_d = RESP;
                    beat_d  = '0;
                    idx_d   = fetch_pc_d[5:2];
                end
            end
            RESP: begin
                if (hs && !discard_q) begin
                    idx_d = idx_q + 4'd1;
                end
                if (redirect) begin
                    discard_d  = 1'b1;
                    fetch_pc_d = redir_pc;
                end
                if (bus_respcyc) begin
                    line_d[beat_q[BEAT_W-2:0]] = bus_resp;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = discard_d ? REQ : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    state_d    = REQ;
                end else if (hs) begin
                    if (idx_q == 4'hF) begin
                        fetch_pc_d = {fetch_pc_q[63:6] + 58'd1, 6'b0};
                        state_d    = REQ;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == REQ && state_q != REQ) begin
            discard_d = 1'b0;
        end

        // Outputs are registered, so they are derived from the next-state values.
        bus_reqcyc_d = (state_d == REQ);
        bus_req_d    = bus_req_q;
        bus_reqtag_d = bus_reqtag_q;
        if (state_d == REQ && state_q != REQ) begin
            bus_req_d    = BUS_DATA_WIDTH'({fetch_pc_d[63:6], 6'b0});
            bus_reqtag_d = READ_TAG;
        end

        instr_valid_d = (state_d == DRAIN);
`ifdef IFB_BYPASS_EN
        if (state_d == RESP && !discard_d && ({1'b0, idx_d} < {beat_d, 1'b0})) begin
            instr_valid_d = 1'b1;
        end
`endif

        word_beat  = line_d[idx_d[3:1]];
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (instr_valid_d) begin
            instr_d    = idx_d[0] ? word_beat[63:32] : word_beat[31:0];
            instr_pc_d = {fetch_pc_d[63:6], idx_d, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= '0;
            discard_q     <= 1'b0;
            beat_q        <= '0;
            idx_q         <= '0;
            line_q        <= '0;
            bus_reqcyc_q  <= 1'b0;
            bus_req_q     <= '0;
            bus_reqtag_q  <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            discard_q     <= discard_d;
            beat_q        <= beat_d;
            idx_q         <= idx_d;
            line_q        <= line_d;
            bus_reqcyc_q  <= bus_reqcyc_d;
            bus_req_q     <= bus_req_d;
            bus_reqtag_q  <= bus_reqtag_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign bus_reqcyc  = bus_reqcyc_q;
    assign bus_req     = bus_req_q;
    assign bus_reqtag  = bus_reqtag_q;
    assign bus_respack = bus_respcyc & (state_q == RESP);
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
